// File: rtl/sr4_pkg.sv
// Shared constants for the sr4 shift register.
package sr4_pkg;

  // Default number of stages in the shift chain.
  localparam int DEFAULT_WIDTH = 4;

endpackage : sr4_pkg

// File: rtl/sr4_muxdff.sv
// One shift-register stage: a 2:1 mux feeding a D flip-flop with asynchronous
// active-low clear. Sel=1 picks the load data D1, Sel=0 picks the shift data D0.
module sr4_muxdff (
  input  logic clk,
  input  logic rst_n,
  input  logic D0,
  input  logic D1,
  input  logic Sel,
  output logic Q
);

  logic q_d;
  logic q_q;

  // Stage input mux: load data wins over shift data.
  always_comb begin
    q_d = Sel ? D1 : D0;
  end

  // Stage flop. Clears as soon as rst_n falls, without waiting for a clock edge.
  // NOTE: the reset is in the sensitivity list so the clear is asynchronous;
  // non-blocking assignment keeps every stage sampling pre-edge values of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule : sr4_muxdff

// File: rtl/sr4.sv
// Parallel-load, serial-input shift register. Each rising edge either loads R
// (L=1) or shifts right by one with w entering at the MSB (L=0). Q is driven
// straight from the stage flops.
module sr4
  import sr4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] R,
  input  logic             L,
  input  logic             w,
  output logic [WIDTH-1:0] Q
);

  // Shift source for every stage: bit i+1 of this vector feeds stage i, so the
  // MSB stage takes w and every other stage takes its upper neighbour.
  logic [WIDTH:0] shift_src;

  assign shift_src = {w, Q};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    sr4_muxdff u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .D0    (shift_src[i+1]),
      .D1    (R[i]),
      .Sel   (L),
      .Q     (Q[i])
    );
  end

endmodule : sr4

// File: tb/tb_sr4.sv
// Directed testbench for sr4: reset, load, shift, serial fill, load priority
// and asynchronous reset in the middle of a shift sequence.
`timescale 1ns/1ps
module tb_sr4;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [3:0] R;
  logic       L;
  logic       w;
  logic [3:0] Q;

  int errors;
  int checks;

  sr4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .R     (R),
    .L     (L),
    .w     (w),
    .Q     (Q)
  );

  // Gated clock so the reset test can run with no edges at all.
  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  // Wait for the next rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_clock: Q=%b expected=%b", Q, 4'b0000);
    end
    checks++;
    clk_en = 1'b1;
    tick();
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held: Q=%b expected=%b", Q, 4'b0000);
    end
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    R = 4'b1010; L = 1'b1; w = 1'b1;
    tick();
    if (Q !== 4'b1010) begin
      errors++;
      $display("FAIL load_1010: Q=%b expected=%b", Q, 4'b1010);
    end
    checks++;
    R = 4'b0110;
    tick();
    if (Q !== 4'b0110) begin
      errors++;
      $display("FAIL load_0110: Q=%b expected=%b", Q, 4'b0110);
    end
    checks++;
  endtask

  task automatic test_shift_zeros();
    logic [3:0] exp_q [4];
    exp_q = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    R = 4'b1010; L = 1'b1;
    tick();
    L = 1'b0; w = 1'b0; R = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Q !== exp_q[i]) begin
        errors++;
        $display("FAIL shift_zeros[%0d]: Q=%b expected=%b", i, Q, exp_q[i]);
      end
      checks++;
    end
  endtask

  task automatic test_serial_fill();
    logic [3:0] w_seq;
    logic [3:0] exp_q [4];
    w_seq = 4'b1101;  // applied LSB first: 1,0,1,1
    exp_q = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    L = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = w_seq[i];
      // A glitch on R between edges must not matter while shifting.
      R = 4'(i * 5);
      tick();
      if (Q !== exp_q[i]) begin
        errors++;
        $display("FAIL serial_fill[%0d]: Q=%b expected=%b", i, Q, exp_q[i]);
      end
      checks++;
    end
  endtask

  task automatic test_load_priority();
    R = 4'b1111; L = 1'b1; w = 1'b0;
    tick();
    if (Q !== 4'b1111) begin
      errors++;
      $display("FAIL priority_setup: Q=%b expected=%b", Q, 4'b1111);
    end
    checks++;
    R = 4'b0011; L = 1'b1; w = 1'b0;
    tick();
    if (Q !== 4'b0011) begin
      errors++;
      $display("FAIL load_priority: Q=%b expected=%b", Q, 4'b0011);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    // Build Q=1101 by shifting in 1,0,1,1 from a cleared register.
    R = 4'b0000; L = 1'b1;
    tick();
    L = 1'b0;
    w = 1'b1; tick();
    w = 1'b0; tick();
    w = 1'b1; tick();
    w = 1'b1; tick();
    if (Q !== 4'b1101) begin
      errors++;
      $display("FAIL midshift_setup: Q=%b expected=%b", Q, 4'b1101);
    end
    checks++;
    // Drop reset between edges; Q must clear before the next edge.
    #1 rst_n = 1'b0;
    #1;
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL async_clear: Q=%b expected=%b", Q, 4'b0000);
    end
    checks++;
    tick();
    if (Q !== 4'b0000) begin
      errors++;
      $display("FAIL async_hold: Q=%b expected=%b", Q, 4'b0000);
    end
    checks++;
    #2 rst_n = 1'b1;
    L = 1'b0; w = 1'b1;
    tick();
    if (Q !== 4'b1000) begin
      errors++;
      $display("FAIL after_release: Q=%b expected=%b", Q, 4'b1000);
    end
    checks++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    R      = 4'b0000;
    L      = 1'b0;
    w      = 1'b0;

    test_reset();
    test_load();
    test_shift_zeros();
    test_serial_fill();
    test_load_priority();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sr4

// File: doc/sr4.md
# sr4

4-bit parallel-load, serial-input shift register. Each rising clock edge either loads a parallel word or shifts right by one bit, with the serial input entering at the MSB. The block is a general-purpose datapath element for serial-to-parallel conversion and for loading a register that is then shifted out. The bit order is the classic per-bit mux-plus-flip-flop chain (Q[3] → Q[0]).

## Interface
- WIDTH, default 4: number of register stages; all behaviour below is written for WIDTH=4 and scales linearly.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous and active-low; clears every stage.
- R  input  WIDTH  parallel load data.
- L  input  1  load enable, active-high; selects R over shift.
- w  input  1  serial input, shifted into the MSB.
- Q  output  WIDTH  register contents (Q[3] = MSB, first stage of the shift chain).
- One clock; reset is asynchronous and active-low.

## Operation
- rst_n=0: Q = 0 immediately, independent of clk; holds while asserted.
- Rising clk edge with rst_n=1 and L=1: Q ← R (parallel load).
- Rising clk edge with rst_n=1 and L=0: Q ← {w, Q[3:1]} (shift right). Q[0] is discarded.
- Priority: rst_n over L over shift. L=1 ignores w.
- No hold mode: every non-reset edge either loads or shifts.
- R and w are sampled only at the rising edge; glitches between edges have no effect.
- Q is driven directly from flip-flops; there is no combinational path from inputs to Q.

## Timing
- Latency of one cycle: a load or shift is visible on Q immediately after the edge at which it was sampled.
- Reset assertion takes effect asynchronously, without waiting for a clock edge.
- Reset deassertion is synchronised externally by the system. The first edge after rst_n rises performs a normal load or shift.
- Reset mid-operation: Q clears at once; the current shift sequence is lost, with no partial update.
- L and w changing at the same time: only their values at the edge matter.
- After 4 consecutive shifts with L=0, Q equals the last four w values, with the most recent in Q[3].

## Structure
- Shared package: WIDTH default constant; no typedefs needed.
- Natural sub-module: muxdff, one per stage.
  - Ports: clk, rst_n, D0 (shift data), D1 (load data), Sel (=L), Q.
  - Behaviour: a 2:1 mux feeding a D flip-flop with asynchronous active-low clear.
- Top level: a generate loop of WIDTH muxdff instances.
  - Stage i: D0 = Q[i+1], with w for the MSB stage; D1 = R[i].

## Test plan
- Reset: rst_n=0 with clk idle → Q=0000 without any clock edge.
- Load: rst_n=1, R=1010, L=1, one edge → Q=1010. A second edge with L=1 and R=0110 → Q=0110.
- Shift zeros: start from Q=1010, L=0, w=0; four edges → Q=0101, 0010, 0001, 0000.
- Serial fill: start from Q=0000, L=0; apply w=1,0,1,1 on successive edges → Q=1000, 0100, 1010, 1101.
- Load priority: Q=1111, L=1, w=0, R=0011, one edge → Q=0011 (no shift).
- Async reset mid-shift: Q=1101 while shifting; drop rst_n between edges → Q=0000 immediately. After release, L=0 and w=1 with one edge → Q=1000.
